// File: rtl/multiplier_3bit_if.sv
// Operand/result bundle for the shift-and-add multiplier.
// The master pulses start and reads product when done is high.
interface multiplier_3bit_if #(
  parameter int WIDTH = 3
);
  logic [WIDTH-1:0]   multiplicand;
  logic [WIDTH-1:0]   multiplier;
  logic               start;
  logic               done;
  logic [2*WIDTH-1:0] product;

  modport master (
    output multiplicand,
    output multiplier,
    output start,
    input  done,
    input  product
  );

  modport slave (
    input  multiplicand,
    input  multiplier,
    input  start,
    output done,
    output product
  );
endinterface

// File: rtl/multiplier_3bit.sv
// Sequential unsigned shift-and-add multiplier, one partial
// product per cycle, start/done handshake, registered outputs.
module multiplier_3bit #(
  parameter int WIDTH = 3
) (
  input  logic [WIDTH-1:0]   multiplicand,
  input  logic [WIDTH-1:0]   multiplier,
  input  logic               start,
  input  logic               clk,
  output logic               done,
  output logic [2*WIDTH-1:0] product,
  input  logic               rst_n
);

  localparam int CW = $clog2(WIDTH);
  localparam int PW = 2 * WIDTH;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_BUSY = 1'b1
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [PW-1:0]   r_acc;
  logic [CW-1:0]   r_count;
  logic            r_done;
  logic [PW-1:0]   r_product;

  logic            w_load;
  logic            w_step;
  logic            w_last;
  logic [PW-1:0]   w_a_ext;
  logic [PW-1:0]   w_addend;
  logic [PW-1:0]   w_acc_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE: if (start)  w_state_nxt = S_BUSY;
      S_BUSY: if (w_last) w_state_nxt = S_IDLE;
      default:            w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_load = 1'b0;
    w_step = 1'b0;
    w_last = 1'b0;
    unique case (r_state)
      S_IDLE: w_load = start;
      S_BUSY: begin
        w_step = 1'b1;
        w_last = (r_count == CW'(WIDTH - 1));
      end
      default: ;
    endcase
  end

  assign w_a_ext   = {{WIDTH{1'b0}}, r_a};
  assign w_addend  = r_b[r_count] ? (w_a_ext << r_count) : '0;
  assign w_acc_nxt = r_acc + w_addend;

  // The final iteration's add goes straight into product.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a       <= '0;
      r_b       <= '0;
      r_acc     <= '0;
      r_count   <= '0;
      r_done    <= 1'b0;
      r_product <= '0;
    end else if (w_load) begin
      r_a     <= multiplicand;
      r_b     <= multiplier;
      r_acc   <= '0;
      r_count <= '0;
      r_done  <= 1'b0;
    end else if (w_step) begin
      r_acc   <= w_acc_nxt;
      r_count <= r_count + 1'b1;
      if (w_last) begin
        r_product <= w_acc_nxt;
        r_done    <= 1'b1;
      end
    end
  end

  assign done    = r_done;
  assign product = r_product;

endmodule

// File: tb/tb_multiplier_3bit.sv
// Directed bench for multiplier_3bit with a queue of
// expected products popped when done rises.
module tb_multiplier_3bit;

  localparam int W = 3;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;
  logic [2*W-1:0] q_exp[$];
  logic [2*W-1:0] last_prod;

  multiplier_3bit_if #(.WIDTH(W)) mif ();

  multiplier_3bit #(.WIDTH(W)) dut (
    .multiplicand (mif.multiplicand),
    .multiplier   (mif.multiplier),
    .start        (mif.start),
    .clk          (clk),
    .done         (mif.done),
    .product      (mif.product),
    .rst_n        (rst_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic op(input int a, input int b, input bit disturb);
    int n;
    logic [2*W-1:0] e;
    @(negedge clk);
    mif.multiplicand = W'(a);
    mif.multiplier   = W'(b);
    mif.start        = 1'b1;
    q_exp.push_back((2*W)'(a * b));
    @(posedge clk);
    #1;
    mif.start = 1'b0;
    chk("done_clr", int'(mif.done), 0);
    chk("prod_hold_busy", int'(mif.product), int'(last_prod));
    n = 0;
    while (!mif.done && n < 10) begin
      if (disturb) begin
        @(negedge clk);
        mif.multiplicand = W'($urandom_range(0, 7));
        mif.multiplier   = W'($urandom_range(0, 7));
        mif.start        = (n == 0);
      end
      @(posedge clk);
      #1;
      n++;
    end
    mif.start = 1'b0;
    chk("latency", n, W);
    e = (q_exp.size() > 0) ? q_exp.pop_front() : '0;
    chk("product", int'(mif.product), int'(e));
    last_prod = e;
    repeat (12) @(posedge clk);
    #1;
    chk("done_held", int'(mif.done), 1);
    chk("prod_held", int'(mif.product), int'(e));
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    last_prod = '0;
    rst_n     = 1'b0;
    mif.multiplicand = '0;
    mif.multiplier   = '0;
    mif.start        = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_done", int'(mif.done), 0);
    chk("rst_prod", int'(mif.product), 0);
    @(negedge clk);
    rst_n = 1'b1;

    op(7, 7, 1'b0);
    op(7, 5, 1'b0);
    op(4, 1, 1'b0);
    op(7, 4, 1'b0);
    op(0, 7, 1'b0);
    op(7, 7, 1'b1);

    // Abort a 5x5 run partway through.
    @(negedge clk);
    mif.multiplicand = 3'd5;
    mif.multiplier   = 3'd5;
    mif.start        = 1'b1;
    @(posedge clk);
    #1;
    mif.start = 1'b0;
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("abort_done", int'(mif.done), 0);
    chk("abort_prod", int'(mif.product), 0);
    last_prod = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("abort_stay", int'(mif.done), 0);
    @(negedge clk);
    rst_n = 1'b1;

    op(3, 3, 1'b0);

    chk("queue_empty", q_exp.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
